// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//   Two-port arbiter in front of a single memory port. Port 0 is the fetch
//   side (read only) and port 1 is the data side (read or write). One
//   transaction runs at a time. A transaction ends when mem_ready is seen, or
//   aborts with err after TIMEOUT unanswered wait cycles. Every output is
//   driven straight from a flop.
//
//   Optional feature macro: MEM_ARB_ROUND_ROBIN_EN
//     defined   - simultaneous requests alternate between the two ports,
//                 using the last_served flop.
//     undefined - simultaneous requests always go to port 1 (data priority).
//
// Ports
//   clk, rst_n             clock and asynchronous active-low reset
//   req0, addr0            fetch-side request and address
//   req1, addr1, wdata1,   data-side request, address, write data and
//   we1                    write enable
//   gnt0, gnt1             grant, held for the whole transaction
//   done0, done1           one-cycle completion pulse for each port
//   err                    one-cycle timeout pulse (together with done_x)
//   mem_valid, mem_we,     memory request, held stable while busy
//   mem_addr, mem_wdata
//   mem_ready, mem_rdata   memory handshake and read data
//   rdata                  read data of the last completed transaction
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 15,
  localparam int unsigned DATA_W = 16,
  localparam int unsigned WAIT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic [DATA_W-1:0] addr0,
  input  logic              req1,
  input  logic [DATA_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              we1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              err_q, err_d;
  logic              mem_valid_q, mem_valid_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  logic pick0;
  logic pick1;
  logic timeout_hit;

  // Arbitration: which port wins if the FSM is idle this cycle
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_served_q, last_served_d;

  // On contention, serve the port that did not win last time
  assign pick1 = req1 & (~req0 | ~last_served_q);
`else
  // On contention the data side always wins
  assign pick1 = req1;
`endif
  assign pick0 = req0 & ~pick1;

  assign timeout_hit = (wait_q == WAIT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick1) begin
          state_d = ST_BUSY1;
        end else if (pick0) begin
          state_d = ST_BUSY0;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        // mem_ready wins over a timeout on the same edge
        if (mem_ready || timeout_hit) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; all of them land in flops below
  always_comb begin
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    err_d       = 1'b0;
    mem_valid_d = mem_valid_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    wait_d      = wait_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    last_served_d = last_served_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick1) begin
          gnt1_d      = 1'b1;
          mem_valid_d = 1'b1;
          mem_we_d    = we1;
          mem_addr_d  = addr1;
          mem_wdata_d = wdata1;
          wait_d      = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_served_d = 1'b1;
`endif
        end else if (pick0) begin
          // Fetch side is read only
          gnt0_d      = 1'b1;
          mem_valid_d = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = addr0;
          mem_wdata_d = '0;
          wait_d      = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          last_served_d = 1'b0;
`endif
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        if (mem_ready || timeout_hit) begin
          gnt0_d      = 1'b0;
          gnt1_d      = 1'b0;
          mem_valid_d = 1'b0;
          done0_d     = (state_q == ST_BUSY0);
          done1_d     = (state_q == ST_BUSY1);
          // An abort keeps the previous read data
          if (mem_ready) begin
            rdata_d = mem_rdata;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        gnt0_d      = 1'b0;
        gnt1_d      = 1'b0;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      err_q       <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      wait_q      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_served_q <= 1'b1;
`endif
    end else begin
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      err_q       <= err_d;
      mem_valid_q <= mem_valid_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      wait_q      <= wait_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_served_q <= last_served_d;
`endif
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err       = err_q;
  assign mem_valid = mem_valid_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Self-checking bench for mem_port_arbiter: a vector table from reset,
//   hand-written contention / timeout / reset sequences, then random traffic
//   compared every cycle against a transaction-level reference model.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_mem_port_arbiter;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we1, mem_ready;
  logic [15:0] addr0, addr1, wdata1, mem_rdata;
  logic        gnt0, gnt1, done0, done1, err, mem_valid, mem_we;
  logic [15:0] mem_addr, mem_wdata, rdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .addr0(addr0),
    .req1(req1), .addr1(addr1), .wdata1(wdata1), .we1(we1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .err(err),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .rdata(rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Packed view of every DUT output
  logic [54:0] act_o;
  assign act_o = {gnt0, gnt1, done0, done1, err, mem_valid, mem_we,
                  mem_addr, mem_wdata, rdata};

  function automatic logic [54:0] pk(input logic g0, input logic g1,
                                     input logic d0, input logic d1,
                                     input logic e, input logic v,
                                     input logic w, input logic [15:0] a,
                                     input logic [15:0] wd,
                                     input logic [15:0] rd);
    return {g0, g1, d0, d1, e, v, w, a, wd, rd};
  endfunction

  task automatic chk(input string name, input logic [54:0] act,
                     input logic [54:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req0 = 1'b0; req1 = 1'b0; we1 = 1'b0; mem_ready = 1'b0;
    addr0 = '0; addr1 = '0; wdata1 = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", act_o, 55'd0);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        r0, r1, w1, rdy;
    logic [15:0] a0, a1, wd1, mrd;
    logic [54:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic r0, input logic r1,
                              input logic [15:0] a0, input logic [15:0] a1,
                              input logic [15:0] wd1, input logic w1,
                              input logic rdy, input logic [15:0] mrd,
                              input logic [54:0] exp);
    vec_t v;
    v.r0 = r0; v.r1 = r1; v.a0 = a0; v.a1 = a1; v.wd1 = wd1; v.w1 = w1;
    v.rdy = rdy; v.mrd = mrd; v.exp = exp;
    return v;
  endfunction

  vec_t tbl[14];

  // ---------------- reference model ----------------
  // owner: -1 idle, else the port holding the memory
  int          m_owner, m_waits, m_last;
  logic        m_done0, m_done1, m_err, m_we;
  logic [15:0] m_addr, m_wdata, m_rdata;

  function automatic bit rr_enabled();
`ifdef MEM_ARB_ROUND_ROBIN_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_init();
    m_owner = -1; m_waits = 0; m_last = 1;
    m_done0 = 0; m_done1 = 0; m_err = 0; m_we = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0;
  endtask

  // Apply the arbitration / completion rules for one rising edge
  task automatic model_edge();
    int win;
    win = -1;
    m_done0 = 0; m_done1 = 0; m_err = 0;
    if (m_owner < 0) begin
      if (req0 && req1)  win = rr_enabled() ? 1 - m_last : 1;
      else if (req0)     win = 0;
      else if (req1)     win = 1;
      if (win >= 0) begin
        m_owner = win;
        m_waits = 0;
        m_last  = win;
        m_addr  = (win == 0) ? addr0 : addr1;
        m_wdata = (win == 0) ? 16'h0000 : wdata1;
        m_we    = (win == 0) ? 1'b0 : we1;
      end
    end else if (mem_ready) begin
      if (m_owner == 0) m_done0 = 1; else m_done1 = 1;
      m_rdata = mem_rdata;
      m_owner = -1;
    end else if (m_waits == int'(TO)) begin
      if (m_owner == 0) m_done0 = 1; else m_done1 = 1;
      m_err   = 1;
      m_owner = -1;
    end else begin
      m_waits++;
    end
  endtask

  function automatic logic [54:0] model_out();
    return pk(m_owner == 0, m_owner == 1, m_done0, m_done1, m_err,
              m_owner >= 0, m_we, m_addr, m_wdata, m_rdata);
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    logic [1:0] exp2;
    bit         slow;
    rst_n = 1'b0;
    clear_inputs();
    slow = 1'b0;

    // Reads, writes, request deassertion while busy, request not latched
    tbl[0]  = mk(1,0,16'h0040,16'h0000,16'h0000,0,0,16'h0000, pk(1,0,0,0,0,1,0,16'h0040,16'h0000,16'h0000));
    tbl[1]  = mk(0,0,16'h0040,16'h0000,16'h0000,0,1,16'hBEEF, pk(0,0,1,0,0,0,0,16'h0040,16'h0000,16'hBEEF));
    tbl[2]  = mk(0,0,16'h0000,16'h0000,16'h0000,0,0,16'h0000, pk(0,0,0,0,0,0,0,16'h0040,16'h0000,16'hBEEF));
    tbl[3]  = mk(0,1,16'h0000,16'h1234,16'hA5A5,1,0,16'h0000, pk(0,1,0,0,0,1,1,16'h1234,16'hA5A5,16'hBEEF));
    tbl[4]  = mk(0,0,16'h0000,16'h0000,16'h0000,0,0,16'h0000, pk(0,1,0,0,0,1,1,16'h1234,16'hA5A5,16'hBEEF));
    tbl[5]  = mk(0,0,16'h0000,16'h0000,16'h0000,0,0,16'h0000, pk(0,1,0,0,0,1,1,16'h1234,16'hA5A5,16'hBEEF));
    tbl[6]  = mk(0,0,16'h0000,16'h0000,16'h0000,0,0,16'h0000, pk(0,1,0,0,0,1,1,16'h1234,16'hA5A5,16'hBEEF));
    tbl[7]  = mk(0,0,16'h0000,16'h0000,16'h0000,0,1,16'h5A5A, pk(0,0,0,1,0,0,1,16'h1234,16'hA5A5,16'h5A5A));
    tbl[8]  = mk(0,0,16'h0000,16'h0000,16'h0000,0,0,16'h0000, pk(0,0,0,0,0,0,1,16'h1234,16'hA5A5,16'h5A5A));
    tbl[9]  = mk(1,0,16'h0100,16'h0000,16'h0000,0,1,16'hDEAD, pk(1,0,0,0,0,1,0,16'h0100,16'h0000,16'h5A5A));
    tbl[10] = mk(0,1,16'h0000,16'h0300,16'h7777,1,1,16'h0F0F, pk(0,0,1,0,0,0,0,16'h0100,16'h0000,16'h0F0F));
    tbl[11] = mk(0,0,16'h0000,16'h0000,16'h0000,0,0,16'h0000, pk(0,0,0,0,0,0,0,16'h0100,16'h0000,16'h0F0F));
    tbl[12] = mk(0,1,16'h0000,16'h0300,16'h7777,0,0,16'h0000, pk(0,1,0,0,0,1,0,16'h0300,16'h7777,16'h0F0F));
    tbl[13] = mk(0,0,16'h0000,16'h0000,16'h0000,0,1,16'h0000, pk(0,0,0,1,0,0,0,16'h0300,16'h7777,16'h0000));

    do_reset();
    for (int i = 0; i < 14; i++) begin
      req0 = tbl[i].r0; req1 = tbl[i].r1; addr0 = tbl[i].a0;
      addr1 = tbl[i].a1; wdata1 = tbl[i].wd1; we1 = tbl[i].w1;
      mem_ready = tbl[i].rdy; mem_rdata = tbl[i].mrd;
      step();
      chk($sformatf("table row %0d", i), act_o, tbl[i].exp);
    end

    // Contention: both requests held for four transactions
    do_reset();
    req0 = 1; req1 = 1; addr0 = 16'h0011; addr1 = 16'h0022; mem_ready = 1;
    for (int t = 0; t < 4; t++) begin
      if (rr_enabled()) exp2 = (t % 2 == 0) ? 2'b10 : 2'b01;
      else              exp2 = 2'b01;
      step();
      chk($sformatf("contention grant %0d", t), 55'({gnt0, gnt1}), 55'(exp2));
      if (t == 3) begin req0 = 0; req1 = 0; end
      step();
      chk($sformatf("contention done %0d", t),
          55'({done0, done1, gnt0, gnt1}), 55'({exp2, 2'b00}));
    end

    // Timeout: preload rdata, then let a read go unanswered
    clear_inputs();
    req0 = 1; addr0 = 16'h0500;
    step();
    req0 = 0; mem_ready = 1; mem_rdata = 16'h1357;
    step();
    chk("timeout preload", 55'({done0, rdata}), 55'({1'b1, 16'h1357}));
    mem_ready = 0; mem_rdata = 16'hFFFF; req0 = 1;
    step();
    req0 = 0;
    for (int k = 1; k <= int'(TO); k++) begin
      step();
      chk($sformatf("timeout wait %0d", k),
          55'({gnt0, mem_valid, done0, err}), 55'(4'b1100));
    end
    step();
    chk("timeout abort", 55'({gnt0, mem_valid, done0, err, rdata}),
        55'({4'b0011, 16'h1357}));
    step();
    chk("timeout after", 55'({done0, err}), 55'(2'b00));

    // Timeout edge coinciding with mem_ready: normal completion
    req0 = 1;
    step();
    req0 = 0;
    repeat (TO) step();
    mem_ready = 1; mem_rdata = 16'h2468;
    step();
    chk("timeout tie", 55'({gnt0, mem_valid, done0, err, rdata}),
        55'({4'b0010, 16'h2468}));
    mem_ready = 0;
    step();

    // Asynchronous reset in the middle of a BUSY1 transaction
    req1 = 1; addr1 = 16'h4444; wdata1 = 16'h5555; we1 = 1;
    step();
    req1 = 0;
    step();
    chk("pre-reset busy1", 55'({gnt1, mem_valid, mem_we}), 55'(3'b111));
    #2;
    rst_n = 0;
    #1;
    chk("async reset", act_o, 55'd0);
    step();
    chk("reset held", act_o, 55'd0);
    rst_n = 1;
    req0 = 1; req1 = 1; addr0 = 16'h0A0A; addr1 = 16'h0B0B; wdata1 = 16'h0000; we1 = 0;
    step();
    if (rr_enabled())
      chk("post-reset arb", act_o, pk(1,0,0,0,0,1,0,16'h0A0A,16'h0000,16'h0000));
    else
      chk("post-reset arb", act_o, pk(0,1,0,0,0,1,0,16'h0B0B,16'h0000,16'h0000));
    clear_inputs();
    mem_ready = 1;
    step();
    mem_ready = 0;

    // Random traffic against the reference model
    do_reset();
    model_init();
    for (int c = 0; c < 3000; c++) begin
      if (c % 150 == 0) slow = ($urandom_range(0, 1) == 1);
      req0      = ($urandom_range(0, 3) == 0);
      req1      = ($urandom_range(0, 3) == 0);
      addr0     = 16'($urandom);
      addr1     = 16'($urandom);
      wdata1    = 16'($urandom);
      we1       = 1'($urandom);
      mem_rdata = 16'($urandom);
      mem_ready = slow ? ($urandom_range(0, 39) == 0) : ($urandom_range(0, 1) == 1);
      model_edge();
      step();
      chk($sformatf("random cycle %0d", c), act_o, model_out());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low, with ports clk and rst_n.
REQ-002 Parameter TIMEOUT SHALL default to 15 and set the maximum number of BUSY cycles to wait for mem_ready (legal range 1..255).
REQ-003 Port clk SHALL be input, 1 bit, the rising-edge clock.
REQ-004 Port rst_n SHALL be input, 1 bit, the asynchronous active-low reset.
REQ-005 Port req0 SHALL be input, 1 bit, the fetch-side request; addr0 SHALL be input, 16 bits, the fetch address.
REQ-006 Port req1 SHALL be input, 1 bit, the data-side request; addr1, wdata1 SHALL be inputs, 16 bits each; we1 SHALL be input, 1 bit, write enable.
REQ-007 Ports gnt0 and gnt1 SHALL be outputs, 1 bit each, grant held for the whole transaction.
REQ-008 Ports done0 and done1 SHALL be outputs, 1 bit each, single-cycle completion pulses; err SHALL be output, 1 bit, a timeout pulse.
REQ-009 Ports mem_valid and mem_we SHALL be outputs, 1 bit each; mem_addr and mem_wdata SHALL be outputs, 16 bits each; mem_ready SHALL be input, 1 bit; mem_rdata SHALL be input, 16 bits.
REQ-010 Port rdata SHALL be output, 16 bits, the registered read data of the last completed transaction.

Function
REQ-011 The FSM SHALL have three states, IDLE, BUSY0 and BUSY1, and all outputs SHALL be registered.
REQ-012 In IDLE with exactly one request high at a rising edge, the FSM SHALL enter the matching BUSYx state on that edge.
- The same edge SHALL capture the requester's address, write data and write enable into mem_addr, mem_wdata and mem_we.
REQ-013 mem_we SHALL be 0 for port 0, and mem_wdata SHALL be 0 for port 0.
REQ-014 In BUSYx, gnt_x and mem_valid SHALL be 1 and mem_addr, mem_wdata and mem_we SHALL be stable.
REQ-015 In BUSYx, a rising edge with mem_ready=1 SHALL complete the transaction, and the next cycle SHALL show:
- rdata = mem_rdata, for reads and writes alike;
- done_x = 1 for one cycle;
- gnt_x = 0, mem_valid = 0, state IDLE.
REQ-016 At least one IDLE cycle SHALL separate consecutive transactions; the minimum transaction time SHALL be 2 cycles from grant to IDLE.
REQ-017 A wait counter (8 bit) SHALL clear on entry to BUSYx and increment on each BUSY edge with mem_ready=0.
REQ-018 When the wait counter equals TIMEOUT and mem_ready=0, the FSM SHALL complete the transaction as an abort:
- done_x and err SHALL pulse together for one cycle;
- rdata SHALL keep its prior value;
- the FSM SHALL return to IDLE.
REQ-019 If mem_ready=1 on the same edge as the timeout condition, the transaction SHALL complete normally and err SHALL stay 0.
REQ-020 Deassertion of req_x during BUSYx SHALL be ignored; the transaction SHALL run to completion.
REQ-021 Requests arriving during BUSY SHALL NOT be latched; they SHALL be arbitrated only when sampled in IDLE.

Reset
REQ-022 When rst_n=0, the block SHALL immediately force all of the following, asynchronously and regardless of state, including mid-transaction:
- state = IDLE;
- gnt0, gnt1, done0, done1, err, mem_valid, mem_we = 0;
- mem_addr, mem_wdata, rdata = 0x0000;
- wait counter = 0;
- last_served = 1.
REQ-023 The first arbitration SHALL occur on the first rising edge after rst_n deasserts.

Configuration
REQ-024 With macro MEM_ARB_ROUND_ROBIN_EN defined, a simultaneous req0 and req1 in IDLE SHALL be granted to the port not equal to last_served.
- last_served SHALL update to the granted port at every grant.
REQ-025 With MEM_ARB_ROUND_ROBIN_EN undefined, a simultaneous req0 and req1 SHALL always be granted to port 1 (data priority), and last_served SHALL be unused.

Verification
REQ-026 Read, port 0: req0=1, addr0=0x0040, mem_ready=1 on the first BUSY cycle, mem_rdata=0xBEEF -> gnt0 high 1 cycle, then done0 pulse, rdata=0xBEEF, mem_we=0.
REQ-027 Write, port 1: addr1=0x1234, wdata1=0xA5A5, we1=1, mem_ready after 3 cycles -> mem_valid high 4 cycles, mem_we=1, done1 pulse, err=0.
REQ-028 Contention: req0 and req1 held high for 4 transactions -> grants 0,1,0,1 with round robin enabled; 1,1,1,1 without it.
REQ-029 Timeout: TIMEOUT=15, mem_ready held 0 -> done plus err pulse after 16 BUSY cycles, rdata unchanged; mem_ready=1 on the timeout edge -> err=0.
REQ-030 Mid-transaction reset: rst_n pulsed low in BUSY1 -> all outputs zero immediately; after release, simultaneous requests with round robin enabled -> port 0 granted first.
